// File: rtl/text_msg_ctrl_if.sv
// Request/acknowledge handshake between the game-state logic and text_msg_ctrl.
// The master is the requester; the slave is the loader.
interface text_msg_ctrl_if;
  logic       msg_req;
  logic [3:0] msg_id;
  logic       msg_ack;
  logic       msg_err;
  logic       busy;

  modport master (
    output msg_req, msg_id,
    input  msg_ack, msg_err, busy
  );

  modport slave (
    input  msg_req, msg_id,
    output msg_ack, msg_err, busy
  );
endinterface

// File: rtl/text_msg_ctrl.sv
// Clears the 16x16 text buffer and copies a null-terminated ROM message into it.
// Define TEXT_BLINK_EN to add the frame-counted blink of text_visible.
module text_msg_ctrl #(
  parameter int          MSG_COUNT    = 16,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [7:0]  FILL_CHAR    = 8'h20
) (
  input  logic            clk,
  input  logic            rst,
  text_msg_ctrl_if.slave  req,
  output logic [11:0]     rom_addr,
  input  logic [7:0]      rom_data,
  output logic            buf_we,
  output logic [7:0]      buf_addr,
  output logic [7:0]      buf_data,
  input  logic            frame_tick,
  output logic            text_visible
);

  typedef enum logic [2:0] {IDLE, CLEAR, READ, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  idx, idx_nxt;
  logic [3:0]  id, id_nxt;
  logic        ack_nxt, err_nxt, busy_nxt, we_nxt;
  logic [11:0] rom_addr_nxt;
  logic [7:0]  addr_nxt, data_nxt;
  logic        id_valid;

  assign id_valid = (int'(id) < MSG_COUNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      id          <= '0;
      req.msg_ack <= 1'b0;
      req.msg_err <= 1'b0;
      req.busy    <= 1'b0;
      rom_addr    <= '0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      id          <= id_nxt;
      req.msg_ack <= ack_nxt;
      req.msg_err <= err_nxt;
      req.busy    <= busy_nxt;
      rom_addr    <= rom_addr_nxt;
      buf_we      <= we_nxt;
      buf_addr    <= addr_nxt;
      buf_data    <= data_nxt;
    end
  end

  // Outputs are computed for the state being entered so every strobe is a flop.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    id_nxt       = id;
    ack_nxt      = 1'b0;
    err_nxt      = req.msg_err;
    busy_nxt     = req.busy;
    we_nxt       = 1'b0;
    rom_addr_nxt = rom_addr;
    addr_nxt     = buf_addr;
    data_nxt     = buf_data;
    unique case (state)
      IDLE: begin
        if (req.msg_req) begin
          state_nxt = CLEAR;
          id_nxt    = req.msg_id;
          idx_nxt   = '0;
          busy_nxt  = 1'b1;
          we_nxt    = 1'b1;
          addr_nxt  = '0;
          data_nxt  = FILL_CHAR;
        end
      end
      CLEAR: begin
        if (idx == 8'hFF) begin
          idx_nxt = '0;
          if (id_valid) begin
            state_nxt    = READ;
            rom_addr_nxt = {id, 8'h00};
          end else begin
            state_nxt = DONE;
            ack_nxt   = 1'b1;
            err_nxt   = 1'b1;
          end
        end else begin
          idx_nxt  = idx + 8'd1;
          we_nxt   = 1'b1;
          addr_nxt = idx + 8'd1;
          data_nxt = FILL_CHAR;
        end
      end
      // rom_data answers the address registered on entry to READ, so the
      // write strobe is prepared here and is a terminator flag in WRITE.
      READ: begin
        state_nxt = WRITE;
        we_nxt    = (rom_data != 8'h00);
        addr_nxt  = idx;
        data_nxt  = rom_data;
      end
      WRITE: begin
        if (!buf_we || idx == 8'hFF) begin
          state_nxt = DONE;
          ack_nxt   = 1'b1;
        end else begin
          state_nxt    = READ;
          idx_nxt      = idx + 8'd1;
          rom_addr_nxt = {id, idx + 8'd1};
        end
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        err_nxt   = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef TEXT_BLINK_EN
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_FRAME = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] frame_cnt;

  // A finished load restarts the blink phase visible, even on a frame tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt    <= '0;
      text_visible <= 1'b1;
    end else if (state == DONE) begin
      frame_cnt    <= '0;
      text_visible <= 1'b1;
    end else if (frame_tick) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt    <= '0;
        text_visible <= ~text_visible;
      end else begin
        frame_cnt <= frame_cnt + CW'(1);
      end
    end
  end
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_frame_tick;

  assign unused_frame_tick = frame_tick;
  assign text_visible      = 1'b1;
`endif

endmodule
